// File: rtl/rsa_modexp_sequencer.sv
// rsa_modexp_sequencer: computes z = x^e mod n by left-to-right
// square-and-multiply over one shared Montgomery multiplier
// (mm_z = mm_a*mm_b*R^-1 mod n, R = 2^BITS).
// Ports: clk, reset (async, active-high); start/stop level controls;
// x/e/n/r2 operands (r2 = R^2 mod n); mm_go/mm_a/mm_b/mm_n request and
// mm_done/mm_z result of the multiplier; z result, busy, done pulse.
// Option: define SKIP_LEADING_ZEROS_EN to start the loop at the MSB of e.
module rsa_modexp_sequencer #(
   parameter int BITS = 64,
   parameter int CW   = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            stop,
   input  logic [BITS-1:0] x,
   input  logic [BITS-1:0] e,
   input  logic [BITS-1:0] n,
   input  logic [BITS-1:0] r2,
   output logic            mm_go,
   output logic [BITS-1:0] mm_a,
   output logic [BITS-1:0] mm_b,
   output logic [BITS-1:0] mm_n,
   input  logic            mm_done,
   input  logic [BITS-1:0] mm_z,
   output logic [BITS-1:0] z,
   output logic            busy,
   output logic            done
);

   localparam int IW = $clog2(BITS);
   localparam logic [BITS-1:0] ONE = BITS'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRIO, S_ISSUE, S_WAIT, S_DRAIN, S_FIN
   } state_t;

   typedef enum logic [2:0] {
      T_CONV_X, T_CONV_ONE, T_SQR, T_MUL, T_FROM_M
   } step_t;

   state_t          state_q, state_d;
   step_t           step_q, step_d;
   logic [CW-1:0]   idx_q, idx_d;
   logic [BITS-1:0] x_q, x_d, e_q, e_d, n_q, n_d, r2_q, r2_d;
   logic [BITS-1:0] xbar_q, xbar_d, acc_q, acc_d, z_q, z_d;
   logic            e_bit;

   assign e_bit = e_q[idx_q[IW-1:0]];

`ifdef SKIP_LEADING_ZEROS_EN
   logic [CW-1:0] msb;

   // Highest set bit of the latched exponent wins.
   always_comb begin
      msb = '0;
      for (int i = 0; i < BITS; i++)
         if (e_q[i]) msb = CW'(i);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         step_q  <= T_CONV_X;
         idx_q   <= '0;
         x_q     <= '0;
         e_q     <= '0;
         n_q     <= '0;
         r2_q    <= '0;
         xbar_q  <= '0;
         acc_q   <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         idx_q   <= idx_d;
         x_q     <= x_d;
         e_q     <= e_d;
         n_q     <= n_d;
         r2_q    <= r2_d;
         xbar_q  <= xbar_d;
         acc_q   <= acc_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      idx_d   = idx_q;
      x_d     = x_q;
      e_d     = e_q;
      n_d     = n_q;
      r2_d    = r2_q;
      xbar_d  = xbar_q;
      acc_d   = acc_q;
      z_d     = z_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               x_d    = x;
               e_d    = e;
               n_d    = n;
               r2_d   = r2;
               step_d = T_CONV_X;
               idx_d  = CW'(BITS - 1);
`ifdef SKIP_LEADING_ZEROS_EN
               state_d = S_PRIO;
`else
               state_d = S_ISSUE;
`endif
            end
         end
`ifdef SKIP_LEADING_ZEROS_EN
         S_PRIO: begin
            if (stop) begin
               state_d = S_IDLE;
            end else begin
               idx_d   = msb;
               state_d = S_ISSUE;
            end
         end
`endif
         // mm_go goes out this cycle, so a stop here still
         // leaves one result in flight that must be drained.
         S_ISSUE: state_d = stop ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            if (stop) begin
               state_d = mm_done ? S_IDLE : S_DRAIN;
            end else if (mm_done) begin
               state_d = S_ISSUE;
               unique case (step_q)
                  T_CONV_X: begin
                     xbar_d = mm_z;
                     step_d = T_CONV_ONE;
                  end
                  T_CONV_ONE: begin
                     acc_d  = mm_z;
                     step_d = T_SQR;
`ifdef SKIP_LEADING_ZEROS_EN
                     if (e_q == '0) step_d = T_FROM_M;
`endif
                  end
                  T_SQR: begin
                     acc_d = mm_z;
                     if (e_bit)
                        step_d = T_MUL;
                     else if (idx_q == '0)
                        step_d = T_FROM_M;
                     else
                        idx_d = idx_q - CW'(1);
                  end
                  T_MUL: begin
                     acc_d = mm_z;
                     if (idx_q == '0) begin
                        step_d = T_FROM_M;
                     end else begin
                        idx_d  = idx_q - CW'(1);
                        step_d = T_SQR;
                     end
                  end
                  T_FROM_M: begin
                     z_d     = mm_z;
                     state_d = S_FIN;
                  end
                  default: state_d = S_IDLE;
               endcase
            end
         end
         S_DRAIN: if (mm_done) state_d = S_IDLE;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operands stay on the bus for the whole request, drain included.
   always_comb begin
      mm_a = '0;
      mm_b = '0;
      if (state_q == S_ISSUE || state_q == S_WAIT ||
          state_q == S_DRAIN) begin
         unique case (step_q)
            T_CONV_X:   begin mm_a = x_q;   mm_b = r2_q;   end
            T_CONV_ONE: begin mm_a = ONE;   mm_b = r2_q;   end
            T_SQR:      begin mm_a = acc_q; mm_b = acc_q;  end
            T_MUL:      begin mm_a = acc_q; mm_b = xbar_q; end
            T_FROM_M:   begin mm_a = acc_q; mm_b = ONE;    end
            default:    begin mm_a = '0;    mm_b = '0;     end
         endcase
      end
   end

   assign mm_go = (state_q == S_ISSUE);
   assign mm_n  = n_q;
   assign z     = z_q;
   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_FIN);

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
// Bench for rsa_modexp_sequencer: random-latency Montgomery multiplier
// model, pow-mod reference, directed and random operations.
module tb_rsa_modexp_sequencer;

   localparam int BITS = 64;
   localparam int CW   = 7;

   logic            clk = 1'b0;
   logic            reset, start, stop;
   logic [BITS-1:0] x, e, n, r2;
   logic            mm_go, mm_done;
   logic [BITS-1:0] mm_a, mm_b, mm_n, mm_z, z;
   logic            busy, done;

   int checks = 0;
   int errors = 0;

   int go_cnt   = 0;
   int stab_err = 0;
   int ovl_err  = 0;
   int mn_err   = 0;
   bit pend     = 1'b0;
   logic [BITS-1:0] cur_n = '0;

   rsa_modexp_sequencer #(.BITS(BITS), .CW(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .x(x), .e(e), .n(n), .r2(r2),
      .mm_go(mm_go), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n),
      .mm_done(mm_done), .mm_z(mm_z),
      .z(z), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // a*b*2^-64 mod nn: reduce, then halve mod nn 64 times.
   function automatic logic [63:0] mont(input logic [63:0] a,
                                        input logic [63:0] b,
                                        input logic [63:0] nn);
      logic [128:0] t;
      t = ({65'd0, a} * {65'd0, b}) % {65'd0, nn};
      for (int i = 0; i < 64; i++)
         t = t[0] ? ((t + {65'd0, nn}) >> 1) : (t >> 1);
      return t[63:0];
   endfunction

   function automatic logic [63:0] powmod(input logic [63:0] b,
                                          input logic [63:0] ee,
                                          input logic [63:0] nn);
      logic [127:0] r, p, m;
      m = {64'd0, nn};
      r = 128'd1 % m;
      p = {64'd0, b} % m;
      for (int i = 0; i < 64; i++) begin
         if (ee[i]) r = (r * p) % m;
         p = (p * p) % m;
      end
      return r[63:0];
   endfunction

   function automatic logic [63:0] r2calc(input logic [63:0] nn);
      logic [127:0] t;
      t = 128'd1;
      for (int i = 0; i < 128; i++)
         t = (t << 1) % {64'd0, nn};
      return t[63:0];
   endfunction

   function automatic int exp_go(input logic [63:0] ev);
`ifdef SKIP_LEADING_ZEROS_EN
      int m;
      if (ev == 64'd0) return 3;
      m = 0;
      for (int i = 0; i < 64; i++)
         if (ev[i]) m = i;
      return 3 + m + 1 + $countones(ev);
`else
      return 3 + BITS + $countones(ev);
`endif
   endfunction

   // Multiplier model: one request at a time, latency 1..20 cycles.
   initial begin : mm_model
      logic [BITS-1:0] ha, hb;
      int lat;
      mm_done = 1'b0;
      mm_z    = '0;
      ha      = '0;
      hb      = '0;
      lat     = 0;
      forever begin
         @(negedge clk);
         mm_done = 1'b0;
         if (reset) begin
            pend = 1'b0;
            lat  = 0;
         end else if (pend) begin
            if (mm_a !== ha || mm_b !== hb) stab_err++;
            if (mm_go) ovl_err++;
            lat--;
            if (lat == 0) begin
               mm_done = 1'b1;
               mm_z    = mont(ha, hb, cur_n);
               pend    = 1'b0;
            end
         end else if (mm_go) begin
            go_cnt++;
            ha   = mm_a;
            hb   = mm_b;
            pend = 1'b1;
            lat  = $urandom_range(1, 20);
            if (mm_n !== cur_n) mn_err++;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " mm_go"}, 64'(mm_go), 64'd0);
      check({tag, " mm_a"}, mm_a, 64'd0);
      check({tag, " mm_b"}, mm_b, 64'd0);
      check({tag, " mm_n"}, mm_n, 64'd0);
      check({tag, " z"}, z, 64'd0);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
   endtask

   task automatic launch(input logic [63:0] xv, input logic [63:0] ev,
                         input logic [63:0] nv);
      @(negedge clk);
      x     = xv;
      e     = ev;
      n     = nv;
      r2    = r2calc(nv);
      cur_n = nv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x     = ~xv;
      e     = ~ev;
      n     = 64'd0;
      r2    = 64'd0;
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 8000 && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      check({tag, " done seen"}, 64'(done), 64'd1);
   endtask

   task automatic run_op(input string tag, input logic [63:0] xv,
                         input logic [63:0] ev, input logic [63:0] nv);
      int base;
      base = go_cnt;
      launch(xv, ev, nv);
      check({tag, " busy"}, 64'(busy), 64'd1);
      wait_done(tag);
      check({tag, " z"}, z, powmod(xv, ev, nv));
      check({tag, " mm_go count"}, 64'(go_cnt - base), 64'(exp_go(ev)));
      @(negedge clk);
      check({tag, " idle after"}, 64'({busy, done}), 64'd0);
   endtask

   initial begin : main
      int base, k;
      bit sawdone;
      logic [63:0] zprev, nv, xv, ev, xa, xb;

      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      x     = '0;
      e     = '0;
      n     = '0;
      r2    = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_zero("reset");

      run_op("x2e5", 64'd2, 64'd5, 64'd13);
      run_op("e0", 64'd7, 64'd0, 64'd13);
      run_op("big", 64'h1234, 64'h10001, 64'hFFFFFFFFFFFFFFC5);

      for (int t = 0; t < 4; t++) begin
         nv = {1'b1, 31'($urandom), 32'($urandom)} | 64'd1;
         xv = {32'($urandom), 32'($urandom)} % nv;
         ev = {32'($urandom), 32'($urandom)};
         if (t == 1) ev = ev >> 40;
         run_op("rand", xv, ev, nv);
      end

      // stop during the wait of the third multiply
      zprev = z;
      launch(64'h55, 64'hF0F0, 64'hFFFFFFFFFFFFFFC5);
      k = 0;
      for (int i = 0; i < 500 && k < 3; i++) begin
         @(negedge clk);
         if (mm_go) k++;
      end
      base = go_cnt;
      @(posedge clk);
      #1 stop = 1'b1;
      sawdone = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 stop = 1'b0;
         if (done) sawdone = 1'b1;
         if (!busy) break;
      end
      check("stop busy low", 64'(busy), 64'd0);
      check("stop idle on mm_done", 64'(mm_done), 64'd1);
      check("stop no done", 64'(sawdone), 64'd0);
      check("stop z kept", z, zprev);
      @(negedge clk);
      check("stop no new go", 64'(go_cnt - base), 64'd0);
      run_op("after stop", 64'd9, 64'd77, 64'd1000003);

      // start held high across two operations, x changing between
      nv = 64'hFFFFFFFFFFFFFFC5;
      ev = 64'h8421;
      xa = 64'h1111_2222;
      xb = 64'h3333_4444_5555;
      base = go_cnt;
      @(negedge clk);
      x     = xa;
      e     = ev;
      n     = nv;
      r2    = r2calc(nv);
      cur_n = nv;
      start = 1'b1;
      @(negedge clk);
      x = xb;
      wait_done("hold1");
      check("hold1 z", z, powmod(xa, ev, nv));
      @(negedge clk);
      check("hold gap idle", 64'(busy), 64'd0);
      @(negedge clk);
      check("hold restart", 64'(busy), 64'd1);
      start = 1'b0;
      x     = 64'hDEAD;
      wait_done("hold2");
      check("hold2 z", z, powmod(xb, ev, nv));
      check("hold mm_go count", 64'(go_cnt - base), 64'(2 * exp_go(ev)));
      @(negedge clk);
      check("hold idle after", 64'(busy), 64'd0);

      // asynchronous reset mid-loop
      launch(64'h77, 64'hFFFF_0000_FFFF, 64'hFFFFFFFFFFFFFFC5);
      k = 0;
      for (int i = 0; i < 2000 && k < 20; i++) begin
         @(negedge clk);
         if (mm_go) k++;
      end
      #2 reset = 1'b1;
      #1 check_zero("async reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_op("after reset", 64'd12345, 64'd65537, 64'd999999937);

      check("mm operand stability", 64'(stab_err), 64'd0);
      check("mm overlap", 64'(ovl_err), 64'd0);
      check("mm_n value", 64'(mn_err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
